fetch_sequencer: RTL and testbench

- Sequences the program counter register for the q1 RISC-V core.
- Each cycle it computes the value loaded into the PC register's next-PC input: hold, +4, or a redirect target.
- Issues instruction-memory requests with a req/gnt/rvalid handshake and delivers fetched instructions to decode with valid/ready.
- Sits between the PC register, instruction memory and decode/execute. Execute supplies branch/jump redirects.

---
 rtl/fetch_sequencer.sv | 175 +++++++++++++++++
 tb/tb_fetch_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//
// Program counter sequencer for the q1 RISC-V core. Each cycle it computes the
// value for the PC register's next-PC input (hold, +4 or redirect target). It
// issues instruction fetches over a req/gnt/rvalid handshake and hands the
// fetched words to decode over valid/ready. At most one fetch is outstanding.
//
// Optional feature: define FETCH_MISALIGN_TRAP_EN to trap misaligned
// redirect targets to TRAP_VEC. This also adds the fetch_fault output.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   pc_in             current PC from the PC register
//   next_pc_out       next-PC value for the PC register
//   imem_*            instruction memory request/grant/response
//   inst_valid/ready  delivery handshake to decode (inst_out, inst_pc)
//   redirect_*        branch/jump redirect from execute (one-cycle pulse)
//   halt              stop fetching (level); the HALT state exits only by reset
//   busy              high in REQ, WAIT and DLV
//   fetch_count       number of delivered, non-killed instructions
//   fetch_fault       (optional) one-cycle pulse after a misaligned redirect
// ---------------------------------------------------------------------------
module fetch_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] TRAP_VEC = 32'h0000_0100,
   parameter int unsigned CNT_W    = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      pc_in,
   output logic [31:0]      next_pc_out,
   output logic             imem_req,
   output logic [31:0]      imem_addr,
   input  logic             imem_gnt,
   input  logic             imem_rvalid,
   input  logic [31:0]      imem_rdata,
   output logic             inst_valid,
   output logic [31:0]      inst_out,
   output logic [31:0]      inst_pc,
   input  logic             inst_ready,
   input  logic             redirect_en,
   input  logic [31:0]      redirect_target,
   input  logic             halt,
   output logic             busy,
`ifdef FETCH_MISALIGN_TRAP_EN
   output logic             fetch_fault,
`endif
   output logic [CNT_W-1:0] fetch_count
);

   typedef enum logic [2:0] {StIdle, StReq, StWait, StDlv, StHalt} state_t;

   state_t           state_q, state_d;
   logic             drop_q, drop_d;
   logic [31:0]      inst_out_q, inst_pc_q;
   logic [CNT_W-1:0] fetch_count_q;
   logic             load_inst;
   logic             count_en;
   logic             dlv_hs;
   logic [31:0]      redir_pc;

   assign dlv_hs = (state_q == StDlv) && inst_ready;

`ifdef FETCH_MISALIGN_TRAP_EN
   logic misaligned;
   logic fetch_fault_q;

   assign misaligned = |redirect_target[1:0];
   assign redir_pc   = misaligned ? TRAP_VEC : {redirect_target[31:2], 2'b00};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_fault_q <= 1'b0;
      end else begin
         fetch_fault_q <= redirect_en && misaligned;
      end
   end

   assign fetch_fault = fetch_fault_q;
`else
   logic unused_bits;

   // Low target bits are dropped on purpose; TRAP_VEC only matters with the trap.
   assign unused_bits = ^{redirect_target[1:0], TRAP_VEC};
   assign redir_pc    = {redirect_target[31:2], 2'b00};
`endif

   // Next-PC mux: redirect beats the delivery increment, otherwise hold.
   always_comb begin
      next_pc_out = pc_in;
      if (reset) begin
         next_pc_out = RESET_PC;
      end else if (redirect_en) begin
         next_pc_out = redir_pc;
      end else if (dlv_hs) begin
         next_pc_out = pc_in + 32'd4;
      end
   end

   always_comb begin
      state_d   = state_q;
      drop_d    = drop_q;
      load_inst = 1'b0;
      count_en  = 1'b0;
      imem_req  = 1'b0;
      unique case (state_q)
         StIdle: state_d = StReq;
         StReq: begin
            if (halt) begin
               state_d = StHalt;
            end else begin
               imem_req = 1'b1;
               if (imem_gnt) begin
                  state_d = StWait;
                  // Request went out with the old PC; its data must be discarded.
                  drop_d  = redirect_en;
               end
            end
         end
         StWait: begin
            if (imem_rvalid) begin
               drop_d = 1'b0;
               if (drop_q || redirect_en) begin
                  state_d = StReq;
               end else begin
                  load_inst = 1'b1;
                  state_d   = StDlv;
               end
            end else if (redirect_en) begin
               drop_d = 1'b1;
            end
         end
         StDlv: begin
            if (redirect_en) begin
               // Held instruction is on the wrong path: kill it, no count.
               state_d = StReq;
            end else if (inst_ready) begin
               count_en = 1'b1;
               state_d  = halt ? StHalt : StReq;
            end
         end
         StHalt: state_d = StHalt;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= StIdle;
         drop_q        <= 1'b0;
         inst_out_q    <= 32'h0;
         inst_pc_q     <= 32'h0;
         fetch_count_q <= '0;
      end else begin
         state_q <= state_d;
         drop_q  <= drop_d;
         if (load_inst) begin
            inst_out_q <= imem_rdata;
            inst_pc_q  <= pc_in;
         end
         if (count_en) begin
            fetch_count_q <= fetch_count_q + CNT_W'(1);
         end
      end
   end

   assign imem_addr   = imem_req ? pc_in : 32'h0;
   assign inst_valid  = (state_q == StDlv);
   assign inst_out    = inst_out_q;
   assign inst_pc     = inst_pc_q;
   assign busy        = (state_q == StReq) || (state_q == StWait) || (state_q == StDlv);
   assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Directed bench for fetch_sequencer. A small PC register lives here and
// closes the next_pc_out -> pc_in loop. Memory and decode are driven step by
// step from the single initial block.
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc;
   logic [31:0] next_pc_out;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic [31:0] inst_out;
   logic [31:0] inst_pc;
   logic        inst_ready;
   logic        redirect_en;
   logic [31:0] redirect_target;
   logic        halt;
   logic        busy;
   logic [31:0] fetch_count;
`ifdef FETCH_MISALIGN_TRAP_EN
   logic        fetch_fault;
   localparam logic [31:0] MisPc = 32'h0000_0100;
`else
   localparam logic [31:0] MisPc = 32'h0000_0040;
`endif

   int tests = 0;
   int fails = 0;

   fetch_sequencer dut (
      .clk             (clk),
      .reset           (reset),
      .pc_in           (pc),
      .next_pc_out     (next_pc_out),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_gnt        (imem_gnt),
      .imem_rvalid     (imem_rvalid),
      .imem_rdata      (imem_rdata),
      .inst_valid      (inst_valid),
      .inst_out        (inst_out),
      .inst_pc         (inst_pc),
      .inst_ready      (inst_ready),
      .redirect_en     (redirect_en),
      .redirect_target (redirect_target),
      .halt            (halt),
      .busy            (busy),
`ifdef FETCH_MISALIGN_TRAP_EN
      .fetch_fault     (fetch_fault),
`endif
      .fetch_count     (fetch_count)
   );

   always #5 clk = ~clk;

   // PC register: resets to RESET_PC and loads next_pc_out every cycle.
   always @(posedge clk or posedge reset) begin
      if (reset) pc <= 32'h0;
      else       pc <= next_pc_out;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Entry: state REQ at address a. Exit: state DLV holding the word for a.
   task automatic do_fetch(input logic [31:0] a);
      chk("req", {31'h0, imem_req}, 32'h1);
      chk("req_addr", imem_addr, a);
      imem_gnt = 1'b1;
      cyc();
      imem_gnt = 1'b0;
      chk("wait_req_low", {31'h0, imem_req}, 32'h0);
      imem_rvalid = 1'b1;
      imem_rdata  = a ^ 32'hA5A5_0000;
      cyc();
      imem_rvalid = 1'b0;
      chk("dlv_valid", {31'h0, inst_valid}, 32'h1);
      chk("dlv_pc", inst_pc, a);
      chk("dlv_inst", inst_out, a ^ 32'hA5A5_0000);
   endtask

   task automatic accept(input logic [31:0] exp_next);
      inst_ready = 1'b1;
      #1;
      chk("hs_next_pc", next_pc_out, exp_next);
      cyc();
      inst_ready = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
      inst_ready = 1'b0; redirect_en = 1'b0; redirect_target = 32'h0; halt = 1'b0;
      cyc();
      cyc();
      chk("rst_next_pc", next_pc_out, 32'h0);
      chk("rst_valid", {31'h0, inst_valid}, 32'h0);
      chk("rst_req", {31'h0, imem_req}, 32'h0);
      chk("rst_count", fetch_count, 32'h0);
      chk("rst_inst", inst_out, 32'h0);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      reset = 1'b0;
      chk("idle_busy", {31'h0, busy}, 32'h0);
      cyc();

      // Straight-line fetch 0, 4, 8 with a stall on 8.
      do_fetch(32'h0);
      accept(32'h4);
      do_fetch(32'h4);
      accept(32'h8);
      chk("count2", fetch_count, 32'd2);
      do_fetch(32'h8);
      for (int i = 0; i < 5; i++) begin
         chk("stall_valid", {31'h0, inst_valid}, 32'h1);
         chk("stall_next_pc", next_pc_out, 32'h8);
         chk("stall_pc", inst_pc, 32'h8);
         cyc();
      end
      accept(32'hC);
      chk("count3", fetch_count, 32'd3);
      do_fetch(32'hC);
      accept(32'h10);

      // Redirect while waiting on 0x10: its data must be dropped.
      chk("req10", imem_addr, 32'h10);
      imem_gnt = 1'b1;
      cyc();
      imem_gnt = 1'b0;
      redirect_en = 1'b1; redirect_target = 32'h40;
      #1;
      chk("wait_redir_next_pc", next_pc_out, 32'h40);
      cyc();
      redirect_en = 1'b0;
      imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      cyc();
      imem_rvalid = 1'b0;
      chk("drop_no_valid", {31'h0, inst_valid}, 32'h0);
      do_fetch(32'h40);
      chk("count4", fetch_count, 32'd4);

      // Redirect in the same cycle as a delivery handshake.
      inst_ready = 1'b1; redirect_en = 1'b1; redirect_target = 32'h80;
      #1;
      chk("kill_next_pc", next_pc_out, 32'h80);
      cyc();
      inst_ready = 1'b0; redirect_en = 1'b0;
      chk("kill_valid", {31'h0, inst_valid}, 32'h0);
      chk("kill_count", fetch_count, 32'd4);
      chk("kill_req_addr", imem_addr, 32'h80);

      // Misaligned redirect while in REQ without grant.
      redirect_en = 1'b1; redirect_target = 32'h42;
      #1;
      chk("mis_next_pc", next_pc_out, MisPc);
      cyc();
      redirect_en = 1'b0;
      chk("mis_req_addr", imem_addr, MisPc);
`ifdef FETCH_MISALIGN_TRAP_EN
      chk("fault_on", {31'h0, fetch_fault}, 32'h1);
`endif
      cyc();
      chk("mis_hold_addr", imem_addr, MisPc);
`ifdef FETCH_MISALIGN_TRAP_EN
      chk("fault_off", {31'h0, fetch_fault}, 32'h0);
`endif

      // PC increment wraps from 0xFFFFFFFC to 0.
      redirect_en = 1'b1; redirect_target = 32'hFFFF_FFFC;
      cyc();
      redirect_en = 1'b0;
      do_fetch(32'hFFFF_FFFC);
      accept(32'h0);
      chk("count5", fetch_count, 32'd5);

      // Halt on a delivery handshake.
      do_fetch(32'h0);
      halt = 1'b1;
      accept(32'h4);
      chk("halt_count", fetch_count, 32'd6);
      for (int i = 0; i < 20; i++) begin
         chk("halt_busy", {31'h0, busy}, 32'h0);
         chk("halt_req", {31'h0, imem_req}, 32'h0);
         chk("halt_valid", {31'h0, inst_valid}, 32'h0);
         cyc();
         if (i == 10) halt = 1'b0;
      end
      chk("halt_pc_hold", next_pc_out, 32'h4);

      // Reset from HALT, then again in the middle of a WAIT.
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      cyc();
      chk("rst2_req_addr", imem_addr, 32'h0);
      imem_gnt = 1'b1;
      cyc();
      imem_gnt = 1'b0;
      chk("rst2_wait_busy", {31'h0, busy}, 32'h1);
      reset = 1'b1;
      #1;
      chk("midwait_busy", {31'h0, busy}, 32'h0);
      chk("midwait_next_pc", next_pc_out, 32'h0);
      chk("midwait_count", fetch_count, 32'h0);
      cyc();
      chk("midwait_pc", pc, 32'h0);
      reset = 1'b0;
      cyc();
      chk("post_rst_req", {31'h0, imem_req}, 32'h1);
      chk("post_rst_addr", imem_addr, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
